// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_pkg
//  Description : Shared types and helpers for the windowed convolution MAC:
//                FSM state encoding, accumulator width rule and the
//                shift / optional-ReLU / saturate output helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Full-precision accumulator width: one product plus growth for N taps.
    function automatic int acc_width(input int size, input int width);
        return 2 * width + $clog2(size * size);
    endfunction

    // Arithmetic right shift, optional clamp of negatives to zero, then signed
    // saturation into an out_w-bit range. Works on a 64-bit container so the
    // same helper serves every accumulator width up to 64 bits.
    function automatic logic signed [63:0] shift_sat(
        input logic signed [63:0] val,
        input int                 shift,
        input int                 out_w,
        input bit                 relu
    );
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = val >>> shift;
        if (relu && (s < 0)) begin
            s = '0;
        end
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (s > hi) begin
            return hi;
        end
        if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_mac_unit.sv
`default_nettype none
// ============================================================================
//  Module      : conv_mac_unit
//  Description : Registered signed multiply-accumulate. clear has priority
//                over en; products are sign-extended to the accumulator width
//                so nothing is truncated along the way.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_mac_unit #(
    parameter int WIDTH_BIT = 8,
    parameter int ACC_W     = 20
) (
    input  logic                        clock,
    input  logic                        nreset,
    input  logic                        clear,
    input  logic                        en,
    input  logic signed [WIDTH_BIT-1:0] a,
    input  logic signed [WIDTH_BIT-1:0] b,
    output logic signed [ACC_W-1:0]     acc
);

    logic signed [2*WIDTH_BIT-1:0] w_prod;

    assign w_prod = a * b;

    // Accumulator register: cleared on window accept, adds one product per tap.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_W'(w_prod);
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv_window_mac.sv
`default_nettype none
// ============================================================================
//  Module      : conv_window_mac
//  Description : Sequential SIZE x SIZE convolution. Accepts one window per
//                handshake, MACs it one tap per cycle against a runtime
//                loadable signed kernel, then shifts/saturates the result and
//                holds it on a valid/ready output.
//  Config      : CONV_RELU_EN - when defined, negative results clamp to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_window_mac
    import conv_pkg::*;
#(
    parameter int SIZE      = 3,
    parameter int WIDTH_BIT = 8,
    parameter int OUT_W     = 8,
    parameter int SHIFT     = 0
) (
    input  logic                        clock,
    input  logic                        nreset,
    input  logic                        kload_valid,
    input  logic signed [WIDTH_BIT-1:0] kload_data,
    output logic                        kload_ready,
    input  logic                        in_valid,
    input  logic signed [WIDTH_BIT-1:0] in_win [SIZE][SIZE],
    output logic                        in_ready,
    output logic                        out_valid,
    output logic signed [OUT_W-1:0]     out_data,
    input  logic                        out_ready
);

    localparam int                c_N     = SIZE * SIZE;
    localparam int                c_TAP_W = $clog2(c_N);
    localparam int                c_ACC_W = acc_width(SIZE, WIDTH_BIT);
    localparam logic [c_TAP_W-1:0] c_LAST = c_TAP_W'(c_N - 1);
`ifdef CONV_RELU_EN
    localparam bit                c_RELU  = 1'b1;
`else
    localparam bit                c_RELU  = 1'b0;
`endif

    state_t                      r_state;
    state_t                      w_next;
    logic [c_TAP_W-1:0]          r_tap;
    logic [c_TAP_W-1:0]          r_kcnt;
    logic                        r_kernel_ok;
    logic signed [WIDTH_BIT-1:0] r_kern [c_N];
    logic signed [WIDTH_BIT-1:0] r_win  [c_N];
    logic signed [c_ACC_W-1:0]   w_acc;
    logic                        w_accept;
    logic                        w_kload;
    logic                        w_mac_en;
    logic                        w_last_tap;

    // A partially loaded kernel, or a coefficient waiting this cycle, blocks new windows.
    assign kload_ready = (r_state == IDLE);
    assign in_ready    = (r_state == IDLE) && r_kernel_ok && (r_kcnt == '0) && !kload_valid;
    assign w_accept    = in_valid && in_ready;
    assign w_kload     = kload_valid && kload_ready;
    assign w_mac_en    = (r_state == MAC);
    assign w_last_tap  = (r_tap == c_LAST);

    // State register.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and output-valid decode.
    always_comb begin
        w_next    = r_state;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = MAC;
                end
            end
            MAC: begin
                if (w_last_tap) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Tap index walks 0..N-1 while in MAC.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_tap <= '0;
        end else if (w_accept) begin
            r_tap <= '0;
        end else if (w_mac_en) begin
            r_tap <= w_last_tap ? '0 : r_tap + 1'b1;
        end
    end

    // Kernel load: row-major write pointer; the kernel is usable only after a full pass.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < c_N; i++) begin
                r_kern[i] <= '0;
            end
            r_kcnt      <= '0;
            r_kernel_ok <= 1'b0;
        end else if (w_kload) begin
            r_kern[r_kcnt] <= kload_data;
            if (r_kcnt == c_LAST) begin
                r_kcnt      <= '0;
                r_kernel_ok <= 1'b1;
            end else begin
                r_kcnt <= r_kcnt + 1'b1;
                if (r_kcnt == '0) begin
                    r_kernel_ok <= 1'b0;
                end
            end
        end
    end

    // Window snapshot taken at accept so the upstream may move on immediately.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < c_N; i++) begin
                r_win[i] <= '0;
            end
        end else if (w_accept) begin
            for (int r = 0; r < SIZE; r++) begin
                for (int c = 0; c < SIZE; c++) begin
                    r_win[r*SIZE + c] <= in_win[r][c];
                end
            end
        end
    end

    conv_mac_unit #(
        .WIDTH_BIT (WIDTH_BIT),
        .ACC_W     (c_ACC_W)
    ) u_mac (
        .clock  (clock),
        .nreset (nreset),
        .clear  (w_accept),
        .en     (w_mac_en),
        .a      (r_win[r_tap]),
        .b      (r_kern[r_tap]),
        .acc    (w_acc)
    );

    // The accumulator is frozen outside MAC, so the scaled result is stable while held in DONE.
    assign out_data = OUT_W'(shift_sat(64'(w_acc), SHIFT, OUT_W, c_RELU));

endmodule
`default_nettype wire
